// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: operand/issue stage around a fixed-latency ALU.
// Owns the register file (R0 = AC). It snapshots operands at accept, sends a
// one-cycle enable, waits ALU_LAT cycles, then writes back C_bus and Z_flag.
module alu_issue_ctrl #(
  parameter int DATA_W  = 24,
  parameter int NREGS   = 8,
  parameter int ALU_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [2:0]        req_srcb,
  input  logic [2:0]        req_dst,
  input  logic              req_wb,
  input  logic              ext_wr_en,
  input  logic [2:0]        ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic [3:0]        operation,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] C_bus,
  input  logic              Z_flag,
  output logic              z_status,
  output logic              done
);

  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t                        r_state, w_next;
  logic [NREGS-1:0][DATA_W-1:0]  r_regs;
  logic [CW-1:0]                 r_cnt;
  logic [2:0]                    r_dst;
  logic                          r_wb;
  logic                          r_legal;

  logic w_accept, w_legal, w_wb_we;

  // Opcodes 0001..1011 reach the ALU; anything else completes immediately.
  assign w_legal  = (req_op >= 4'd1) && (req_op <= 4'd11);
  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_wb_we  = (r_state == S_WB) && r_wb && r_legal;

  assign req_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_WB);
  assign rd_data   = r_regs[rd_addr];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: illegal ops skip straight to WB so done pulses at t+1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_legal ? S_ISSUE : S_WB;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latency counter: loaded at accept and counted down through ISSUE and WAIT,
  // so WB lands exactly ALU_LAT cycles after the enable pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= CW'(ALU_LAT - 1);
    else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  // Request latch and operand snapshot; buses stay put until the next legal accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dst      <= '0;
      r_wb       <= 1'b0;
      r_legal    <= 1'b0;
      A_bus      <= '0;
      B_bus      <= '0;
      operation  <= '0;
      alu_enable <= 1'b0;
    end else begin
      alu_enable <= w_accept && w_legal;
      if (w_accept) begin
        r_dst   <= req_dst;
        r_wb    <= req_wb;
        r_legal <= w_legal;
        if (w_legal) begin
          A_bus     <= r_regs[0];
          B_bus     <= r_regs[req_srcb];
          operation <= req_op;
        end
      end
    end
  end

  // Register file: ALU write-back takes priority over an external write to the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wb_we && (r_dst == 3'(i)))
          r_regs[i] <= C_bus;
        else if (ext_wr_en && (ext_wr_addr == 3'(i)))
          r_regs[i] <= ext_wr_data;
      end
    end
  end

  // Zero flag capture on completion of every legal op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           z_status <= 1'b0;
    else if ((r_state == S_WB) && r_legal) z_status <= Z_flag;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a 4-cycle behavioural ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wb;
  logic [3:0]  req_op, operation;
  logic [2:0]  req_srcb, req_dst, ext_wr_addr, rd_addr;
  logic        ext_wr_en;
  logic [23:0] ext_wr_data, rd_data, A_bus, B_bus, C_bus;
  logic        alu_enable, Z_flag, z_status, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_srcb(req_srcb), .req_dst(req_dst), .req_wb(req_wb),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .A_bus(A_bus), .B_bus(B_bus),
    .operation(operation), .alu_enable(alu_enable), .C_bus(C_bus),
    .Z_flag(Z_flag), .z_status(z_status), .done(done)
  );

  // Behavioural ALU: result presented for exactly one cycle, 4 cycles after enable.
  logic [23:0]      m_res;
  logic [4:1]       p_v, p_z;
  logic [4:1][23:0] p_c;
  always_comb begin
    m_res = A_bus ^ B_bus;
    if (operation == 4'd1) m_res = A_bus + B_bus;
    if (operation == 4'd2) m_res = A_bus - B_bus;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_v <= '0; p_z <= '0; p_c <= '0;
    end else begin
      p_v <= {p_v[3:1], alu_enable};
      p_z <= {p_z[3:1], (m_res == 24'd0)};
      p_c <= {p_c[3:1], m_res};
    end
  end
  assign C_bus  = p_v[4] ? p_c[4] : 24'd0;
  assign Z_flag = p_v[4] ? p_z[4] : 1'b0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ext_write(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    @(negedge clk);
    ext_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [23:0] d);
    rd_addr = a;
    #1 d = rd_data;
  endtask

  // Issues one request (accept cycle t), then records cycles t+1..t+7.
  // Optional external write is active during cycle t+mk.
  task automatic run_req(input logic [3:0] op, input logic [2:0] srcb, input logic [2:0] dst,
                         input logic wb, input logic mwe, input int mk,
                         input logic [2:0] maddr, input logic [23:0] mdata,
                         output logic [7:1] en_h, output logic [7:1] done_h,
                         output logic [7:1] rdy_h, output logic [7:1][23:0] b_h);
    @(negedge clk);
    req_op = op; req_srcb = srcb; req_dst = dst; req_wb = wb; req_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      en_h[k] = alu_enable; done_h[k] = done; rdy_h[k] = req_ready; b_h[k] = B_bus;
      ext_wr_en = mwe && (k == mk); ext_wr_addr = maddr; ext_wr_data = mdata;
    end
    ext_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [23:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_vec++; if ({alu_enable, done, z_status} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {alu_enable, done, z_status}); end
    n_vec++; if ({A_bus, B_bus, operation} !== 52'd0) begin n_err++; $display("FAIL reset_buses got=%h exp=0", {A_bus, B_bus, operation}); end
    rd(3'd5, d);
    n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL reset_reg5 got=%h exp=0", d); end
  endtask

  task automatic test_add;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    ext_write(3'd0, 24'd5);
    ext_write(3'd1, 24'd3);
    run_req(4'd1, 3'd1, 3'd0, 1'b1, 1'b0, 0, 3'd0, 24'd0, en_h, done_h, rdy_h, b_h);
    n_vec++; if (en_h !== 7'b0000001) begin n_err++; $display("FAIL add_enable got=%b exp=0000001", en_h); end
    n_vec++; if (done_h !== 7'b0010000) begin n_err++; $display("FAIL add_done got=%b exp=0010000", done_h); end
    n_vec++; if (rdy_h !== 7'b1100000) begin n_err++; $display("FAIL add_ready got=%b exp=1100000", rdy_h); end
    n_vec++; if (b_h[1] !== 24'd3) begin n_err++; $display("FAIL add_bbus got=%h exp=3", b_h[1]); end
    n_vec++; if (A_bus !== 24'd5) begin n_err++; $display("FAIL add_abus got=%h exp=5", A_bus); end
    rd(3'd0, d);
    n_vec++; if (d !== 24'd8) begin n_err++; $display("FAIL add_r0 got=%h exp=8", d); end
    n_vec++; if (z_status !== 1'b0) begin n_err++; $display("FAIL add_z got=%b exp=0", z_status); end
  endtask

  task automatic test_sub_zero;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    ext_write(3'd0, 24'd7);
    ext_write(3'd2, 24'd7);
    ext_write(3'd3, 24'h111111);
    run_req(4'd2, 3'd2, 3'd3, 1'b1, 1'b0, 0, 3'd0, 24'd0, en_h, done_h, rdy_h, b_h);
    rd(3'd3, d);
    n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL sub_r3_zero got=%h exp=0", d); end
    n_vec++; if (z_status !== 1'b1) begin n_err++; $display("FAIL sub_z_set got=%b exp=1", z_status); end
    ext_write(3'd2, 24'd2);
    run_req(4'd2, 3'd2, 3'd3, 1'b1, 1'b0, 0, 3'd0, 24'd0, en_h, done_h, rdy_h, b_h);
    rd(3'd3, d);
    n_vec++; if (d !== 24'd5) begin n_err++; $display("FAIL sub_r3_five got=%h exp=5", d); end
    n_vec++; if (z_status !== 1'b0) begin n_err++; $display("FAIL sub_z_clr got=%b exp=0", z_status); end
  endtask

  task automatic test_snapshot;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    logic [4:0][23:0] exp_b;
    ext_write(3'd1, 24'd3);
    exp_b = {5{24'd3}};
    // R0 = 7 here; external write R1 = 9 lands during WAIT
    run_req(4'd1, 3'd1, 3'd6, 1'b1, 1'b1, 2, 3'd1, 24'd9, en_h, done_h, rdy_h, b_h);
    n_vec++; if (b_h[5:1] !== exp_b) begin n_err++; $display("FAIL snap_bbus got=%h exp=%h", b_h[5:1], exp_b); end
    rd(3'd1, d);
    n_vec++; if (d !== 24'd9) begin n_err++; $display("FAIL snap_r1 got=%h exp=9", d); end
    rd(3'd6, d);
    n_vec++; if (d !== 24'd10) begin n_err++; $display("FAIL snap_r6 got=%h exp=a", d); end
  endtask

  task automatic test_collision;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    // R0 = 7, R1 = 9: result 16; ext write collides in the WB cycle
    run_req(4'd1, 3'd1, 3'd4, 1'b1, 1'b1, 5, 3'd4, 24'hABCDEF, en_h, done_h, rdy_h, b_h);
    rd(3'd4, d);
    n_vec++; if (d !== 24'h10) begin n_err++; $display("FAIL coll_same_r4 got=%h exp=10", d); end
    ext_write(3'd4, 24'h000055);
    run_req(4'd1, 3'd1, 3'd4, 1'b1, 1'b1, 5, 3'd5, 24'hABCDEF, en_h, done_h, rdy_h, b_h);
    rd(3'd4, d);
    n_vec++; if (d !== 24'h10) begin n_err++; $display("FAIL coll_diff_r4 got=%h exp=10", d); end
    rd(3'd5, d);
    n_vec++; if (d !== 24'hABCDEF) begin n_err++; $display("FAIL coll_diff_r5 got=%h exp=abcdef", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    logic [8:3] dn;
    // wb=0 op leaves R3 alone and sets z_status (7-7)
    ext_write(3'd2, 24'd7);
    run_req(4'd2, 3'd2, 3'd3, 1'b0, 1'b0, 0, 3'd0, 24'd0, en_h, done_h, rdy_h, b_h);
    rd(3'd3, d);
    n_vec++; if (d !== 24'd5) begin n_err++; $display("FAIL nowb_r3 got=%h exp=5", d); end
    n_vec++; if (z_status !== 1'b1) begin n_err++; $display("FAIL nowb_z got=%b exp=1", z_status); end
    // illegal op then a legal one held valid
    @(negedge clk);
    req_op = 4'hF; req_srcb = 3'd1; req_dst = 3'd0; req_wb = 1'b1; req_valid = 1'b1;
    @(negedge clk);  // t+1
    n_vec++; if ({done, alu_enable, req_ready} !== 3'b100) begin n_err++; $display("FAIL ill_t1 done/en/rdy got=%b exp=100", {done, alu_enable, req_ready}); end
    req_op = 4'd1; req_srcb = 3'd1; req_dst = 3'd7; req_wb = 1'b1;
    @(negedge clk);  // t+2
    n_vec++; if ({done, alu_enable, req_ready} !== 3'b001) begin n_err++; $display("FAIL ill_t2 done/en/rdy got=%b exp=001", {done, alu_enable, req_ready}); end
    n_vec++; if (z_status !== 1'b1) begin n_err++; $display("FAIL ill_z got=%b exp=1", z_status); end
    rd(3'd0, d);
    n_vec++; if (d !== 24'd7) begin n_err++; $display("FAIL ill_r0 got=%h exp=7", d); end
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      dn[k] = done;
      if (k == 3) begin
        n_vec++; if (alu_enable !== 1'b1) begin n_err++; $display("FAIL b2b_enable got=%b exp=1", alu_enable); end
      end
    end
    n_vec++; if (dn !== 6'b010000) begin n_err++; $display("FAIL b2b_done got=%b exp=010000", dn); end
    rd(3'd7, d);
    n_vec++; if (d !== 24'h10) begin n_err++; $display("FAIL b2b_r7 got=%h exp=10", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:1] en_h, done_h, rdy_h; logic [7:1][23:0] b_h; logic [23:0] d;
    logic any_done;
    ext_write(3'd0, 24'd5);
    ext_write(3'd1, 24'd3);
    @(negedge clk);
    req_op = 4'd1; req_srcb = 3'd1; req_dst = 3'd2; req_wb = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);  // in WAIT
    reset = 1'b1;
    #1;
    n_vec++; if ({A_bus, B_bus, operation, alu_enable, z_status, done} !== 55'd0) begin n_err++; $display("FAIL rstmid_outs got=%h exp=0", {A_bus, B_bus, operation, alu_enable, z_status, done}); end
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    n_vec++; if (any_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", any_done); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
    rd(3'd2, d);
    n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL rstmid_r2 got=%h exp=0", d); end
    ext_write(3'd0, 24'd1);
    ext_write(3'd1, 24'd2);
    run_req(4'd1, 3'd1, 3'd0, 1'b1, 1'b0, 0, 3'd0, 24'd0, en_h, done_h, rdy_h, b_h);
    n_vec++; if (done_h !== 7'b0010000) begin n_err++; $display("FAIL rstmid_new_done got=%b exp=0010000", done_h); end
    rd(3'd0, d);
    n_vec++; if (d !== 24'd3) begin n_err++; $display("FAIL rstmid_new_r0 got=%h exp=3", d); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_srcb = '0; req_dst = '0; req_wb = 1'b0;
    ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; rd_addr = '0;
    test_reset;
    test_add;
    test_sub_zero;
    test_snapshot;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand/issue stage sitting directly upstream and downstream of the 24-bit datapath ALU.
- Holds the 8-entry 24-bit register file (R0 = AC).
- Accepts ALU requests over a valid/ready handshake, drives A_bus/B_bus/operation/enable into the ALU, waits the fixed ALU latency, then writes C_bus back and captures Z_flag.
- Also provides an external (memory-load) write port and a debug/read port.

Parameters:
- DATA_W, 24, datapath width of registers and buses.
- NREGS, 8, number of registers; index 0 is AC.
- ALU_LAT, 4, cycles from the enable pulse to C_bus/Z_flag valid.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  stage idle, can accept.
- req_op  in  4  ALU operation code.
- req_srcb  in  3  register index driven on B_bus.
- req_dst  in  3  write-back register index.
- req_wb  in  1  1 = write C_bus into req_dst.
- ext_wr_en  in  1  external register write.
- ext_wr_addr  in  3  external write index.
- ext_wr_data  in  DATA_W  external write data.
- rd_addr  in  3  read-port index.
- rd_data  out  DATA_W  combinational read of register rd_addr.
- A_bus  out  DATA_W  operand A to ALU (AC snapshot).
- B_bus  out  DATA_W  operand B to ALU.
- operation  out  4  opcode to ALU.
- alu_enable  out  1  one-cycle issue pulse to ALU.
- C_bus  in  DATA_W  ALU result.
- Z_flag  in  1  ALU zero flag.
- z_status  out  1  latched zero flag.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state):
  - All registers = 0; A_bus, B_bus, operation, alu_enable, z_status, done = 0.
  - State = IDLE; req_ready = 1 after reset deasserts.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch op/srcb/dst/wb and go to ISSUE.
  - Accept cycle is t.
- ISSUE (t+1):
  - Register A_bus = reg[0] and B_bus = reg[srcb], sampled at end of t (snapshot), and operation = op.
  - alu_enable = 1 for exactly this cycle.
  - Go to WAIT; counter = ALU_LAT-1.
- WAIT:
  - Decrement counter each cycle; A_bus/B_bus/operation held stable.
  - At counter 0, go to WB.
- WB (t+1+ALU_LAT):
  - If wb=1: reg[dst] <= C_bus.
  - z_status <= Z_flag, for every valid op.
  - done = 1 for one cycle; next state IDLE.
- Throughput: one request per ALU_LAT+2 cycles; req_ready = 0 in ISSUE/WAIT/WB.
- Valid opcodes are 0001–1011.
- Opcode 0000 or 1100–1111:
  - Request accepted; no alu_enable, no write-back, z_status unchanged.
  - done pulses at t+1, then IDLE.
- External writes:
  - Commit at any state.
  - Do not affect operands already latched for the current request.
- Collision: WB write and ext write to the same address in the same cycle → ALU write-back wins, ext data dropped. Different addresses → both commit.
- rd_data reflects register contents after the last clock edge; no bypass.
- req_dst = 0 with wb = 1 writes AC.
- req_srcb = 0 drives AC on both buses.
- Reset mid-operation aborts the request, with no write-back and no done.

Test Plan:
- Reset then ext_wr R0=5, R1=3; req op=0001 srcb=1 dst=0 wb=1; ALU model returns C=8 at t+5 → alu_enable only at t+1, done at t+5, rd R0=8, req_ready low t+1..t+5.
- R0=7, R2=7, op=0010 srcb=2 dst=3 wb=1, ALU C=0 Z=1 → R3=0, z_status=1; repeat with R2=2, C=5 Z=0 → z_status=0.
- Operand snapshot: issue with R1=3, ext_wr R1=9 during WAIT → B_bus stays 3 until done, R1 reads 9 afterwards.
- Collision: WB dst=4 with ext_wr_addr=4 data=0xABCDEF in the same cycle → R4 = ALU result; ext write to addr 5 in the same cycle → R5=0xABCDEF.
- Illegal op 1111 → no alu_enable, done at t+1, registers and z_status unchanged; back-to-back valid request accepted at t+2.
- Assert reset during WAIT → all outputs 0, no done, dst register 0, req_ready=1 after release; new request completes normally.
